// File: rtl/tcdm_bank_ctrl_pkg.sv
// Shared helpers for the TCDM bank controller.
// All widths depend on parameters, so the package carries no fixed-width types.
package tcdm_bank_ctrl_pkg;

    // An index over n items is at least one bit wide, even when n is 1.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tcdm_bank_ctrl_fifo.sv
// First-word-registered (not fall-through) response FIFO.
// There is no overflow guard: the caller's credit counter never pushes into a full FIFO.
module tcdm_bank_ctrl_fifo
    import tcdm_bank_ctrl_pkg::*;
#(
    parameter int unsigned Depth = 3,
    parameter type         dtype = logic
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic push_i,
    input  dtype data_i,
    input  logic pop_i,
    output dtype data_o,
    output logic empty_o
);

    localparam int unsigned PtrWidth = idx_width(Depth);
    localparam int unsigned CntWidth = $clog2(Depth + 1);
    localparam logic [PtrWidth-1:0] LastPtr = PtrWidth'(Depth - 1);

    dtype                r_mem [Depth];
    logic [PtrWidth-1:0] r_wr_ptr;
    logic [PtrWidth-1:0] r_rd_ptr;
    logic [CntWidth-1:0] r_cnt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
        end else begin
            if (push_i) r_wr_ptr <= (r_wr_ptr == LastPtr) ? '0 : r_wr_ptr + 1'b1;
            if (pop_i)  r_rd_ptr <= (r_rd_ptr == LastPtr) ? '0 : r_rd_ptr + 1'b1;
            if (push_i && !pop_i)      r_cnt <= r_cnt + 1'b1;
            else if (!push_i && pop_i) r_cnt <= r_cnt - 1'b1;
        end
    end

    // Storage is not reset; empty_o masks stale contents.
    always_ff @(posedge clk_i) begin
        if (push_i) r_mem[r_wr_ptr] <= data_i;
    end

    assign data_o  = r_mem[r_rd_ptr];
    assign empty_o = (r_cnt == '0);

endmodule

// File: rtl/tcdm_bank_ctrl.sv
// Target-side controller: valid/ready request -> single-cycle SRAM access -> tagged response.
// Credits (occ) cover in-flight accesses plus queued responses, so responses never drop.
module tcdm_bank_ctrl
    import tcdm_bank_ctrl_pkg::*;
#(
    parameter int unsigned NumIn        = 32,
    parameter int unsigned DataWidth    = 32,
    parameter int unsigned BeWidth      = DataWidth / 8,
    parameter int unsigned AddrMemWidth = 12,
    parameter int unsigned MemLatency   = 1,
    parameter int unsigned RespDepth    = MemLatency + 2,
    parameter int unsigned NumInLog2    = idx_width(NumIn)
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    req_valid_i,
    output logic                    req_ready_o,
    input  logic [NumInLog2-1:0]    req_ini_addr_i,
    input  logic [AddrMemWidth-1:0] req_tgt_addr_i,
    input  logic                    req_wen_i,
    input  logic [DataWidth-1:0]    req_wdata_i,
    input  logic [BeWidth-1:0]      req_be_i,
    output logic                    resp_valid_o,
    input  logic                    resp_ready_i,
    output logic [NumInLog2-1:0]    resp_ini_addr_o,
    output logic [DataWidth-1:0]    resp_rdata_o,
    output logic                    mem_req_o,
    output logic                    mem_we_o,
    output logic [AddrMemWidth-1:0] mem_addr_o,
    output logic [DataWidth-1:0]    mem_wdata_o,
    output logic [BeWidth-1:0]      mem_be_o,
    input  logic [DataWidth-1:0]    mem_rdata_i
);

    if (MemLatency < 1 || RespDepth < 1) begin : g_bad_params
        $fatal(1, "tcdm_bank_ctrl: MemLatency and RespDepth must both be >= 1");
    end

    localparam int unsigned OccWidth = $clog2(RespDepth + 1);
    localparam logic [OccWidth-1:0] OccMax = OccWidth'(RespDepth);

    typedef struct packed {
        logic [NumInLog2-1:0] ini_addr;
        logic [DataWidth-1:0] rdata;
    } resp_t;

    logic [OccWidth-1:0]                  r_occ;
    logic [MemLatency-1:0]                r_vld_pipe;
    logic [MemLatency-1:0][NumInLog2-1:0] r_ini_pipe;
    logic [MemLatency-1:0]                r_wen_pipe;

    logic  w_accept;
    logic  w_pop;
    logic  w_push;
    logic  w_empty;
    resp_t w_push_data;
    resp_t w_head;

    // Ready comes from registered occupancy only, so a pop frees its credit next cycle.
    assign req_ready_o = (r_occ < OccMax);
    assign w_accept    = req_valid_i & req_ready_o;
    assign w_pop       = resp_valid_o & resp_ready_i;

    assign mem_req_o   = w_accept;
    assign mem_we_o    = req_wen_i;
    assign mem_addr_o  = req_tgt_addr_i;
    assign mem_wdata_o = req_wdata_i;
    assign mem_be_o    = req_be_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_occ <= '0;
        end else if (w_accept && !w_pop) begin
            r_occ <= r_occ + 1'b1;
        end else if (!w_accept && w_pop) begin
            r_occ <= r_occ - 1'b1;
        end
    end

    // Tag travels alongside the SRAM access; last stage lines up with mem_rdata_i.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_vld_pipe <= '0;
            r_ini_pipe <= '0;
            r_wen_pipe <= '0;
        end else begin
            r_vld_pipe[0] <= w_accept;
            r_ini_pipe[0] <= req_ini_addr_i;
            r_wen_pipe[0] <= req_wen_i;
            for (int i = 1; i < MemLatency; i++) begin
                r_vld_pipe[i] <= r_vld_pipe[i-1];
                r_ini_pipe[i] <= r_ini_pipe[i-1];
                r_wen_pipe[i] <= r_wen_pipe[i-1];
            end
        end
    end

    assign w_push               = r_vld_pipe[MemLatency-1];
    assign w_push_data.ini_addr = r_ini_pipe[MemLatency-1];
    assign w_push_data.rdata    = r_wen_pipe[MemLatency-1] ? '0 : mem_rdata_i;

    tcdm_bank_ctrl_fifo #(
        .Depth (RespDepth),
        .dtype (resp_t)
    ) u_resp_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (w_push),
        .data_i  (w_push_data),
        .pop_i   (w_pop),
        .data_o  (w_head),
        .empty_o (w_empty)
    );

    assign resp_valid_o    = ~w_empty;
    assign resp_ini_addr_o = w_head.ini_addr;
    assign resp_rdata_o    = w_head.rdata;

endmodule
